fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder/control unit. Holds the PC and issues one instruction-memory request at a time. Presents the returned word and its PC to decode, then consumes PCSrc/ImmExt/ALUResult from decode/execute to form the next PC (PC+4, branch/jal target, jalr target). Non-speculative: the next fetch issues only in the cycle the current instruction is consumed.

---
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Non-speculative instruction fetch stage: one imem request in flight, next PC formed on consumption.
// Optional macro MISALIGN_TRAP_EN: trap on next_pc[1]=1 (adds misalign_o) instead of forcing alignment.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        instr_valid_o,
    output logic        err_o,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic [1:0]  dbg_state_o
);

    // Handshake: imem_req is a single-cycle pulse; the response is accepted only in WAIT.
    // instr_o is handed to decode while instr_valid_o=1 and is consumed on any cycle with stall=0.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] TIMEOUT_M1 = 32'(IMEM_TIMEOUT) - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;
    logic        req_c;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    always_comb begin
        case (PCSrc)
            2'b01:   next_pc_raw = pc_q + ImmExt;
            2'b10:   next_pc_raw = ALUResult & ~32'h1;
            default: next_pc_raw = pc_q + 32'd4;
        endcase
`ifdef MISALIGN_TRAP_EN
        next_pc = next_pc_raw;
`else
        next_pc = next_pc_raw & ~32'h3;
`endif
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        req_c     = 1'b0;
        imem_addr = RESET_PC;
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                req_c   = 1'b1;
                cnt_d   = 32'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    cnt_d   = 32'd0;
                    state_d = S_VALID;
                end else if ((IMEM_TIMEOUT != 0) && (cnt_q == TIMEOUT_M1)) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_VALID: begin
                imem_addr = next_pc;
                // Responses arriving here are protocol violations and are dropped.
                if (!stall) begin
`ifdef MISALIGN_TRAP_EN
                    if (next_pc[1]) begin
                        err_d      = 1'b1;
                        misalign_d = 1'b1;
                        state_d    = S_ERR;
                    end else begin
`else
                    begin
`endif
                        req_c   = 1'b1;
                        pc_d    = next_pc;
                        state_d = S_WAIT;
                    end
                end
            end
            default: begin
                err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            cnt_q   <= 32'd0;
            err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign imem_req      = req_c & ~rst;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + 32'd4;
    assign instr_valid_o = (state_q == S_VALID);
    assign err_o         = err_q;
    assign dbg_state_o   = state_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_o    = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential/branch/jal/jalr fetch, stall, wrap, timeout, mid-WAIT reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  PCSrc;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_valid_o;
    logic        err_o;
    logic [1:0]  dbg_state_o;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .PCSrc        (PCSrc),
        .ImmExt       (ImmExt),
        .ALUResult    (ALUResult),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .instr_valid_o(instr_valid_o),
        .err_o        (err_o),
`ifdef MISALIGN_TRAP_EN
        .misalign_o   (misalign_o),
`endif
        .dbg_state_o  (dbg_state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in WAIT: one-cycle memory response, then checks the presented instruction.
    task automatic deliver(input logic [31:0] word, input logic [31:0] exp_pc);
        imem_valid = 1'b1;
        imem_rdata = word;
        tick();
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        chk("deliver_state", 32'(dbg_state_o), 32'(ST_VALID));
        chk("deliver_valid", 32'(instr_valid_o), 32'd1);
        chk("deliver_instr", instr_o, word);
        chk("deliver_pc", pc_o, exp_pc);
        chk("deliver_pc4", pc_plus4_o, exp_pc + 32'd4);
    endtask

    // Called in VALID: consume with the given next-PC select and check the request.
    task automatic consume(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu,
                           input logic [31:0] exp_next);
        PCSrc     = src;
        ImmExt    = imm;
        ALUResult = alu;
        stall     = 1'b0;
        #1;
        chk("consume_req", 32'(imem_req), 32'd1);
        chk("consume_addr", imem_addr, exp_next);
        tick();
        stall = 1'b1;
        chk("consume_state", 32'(dbg_state_o), 32'(ST_WAIT));
        chk("consume_valid_drop", 32'(instr_valid_o), 32'd0);
        chk("consume_pc", pc_o, exp_next);
        chk("consume_req_low", 32'(imem_req), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 1'b1;
        PCSrc      = 2'b00;
        ImmExt     = 32'h0;
        ALUResult  = 32'h0;
        imem_rdata = 32'h0;
        imem_valid = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);

        // Cycle 0: request to RESET_PC
        rst = 1'b0;
        #1;
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        tick();
        chk("c1_state", 32'(dbg_state_o), 32'(ST_WAIT));
        chk("c1_req", 32'(imem_req), 32'd0);
        chk("c1_valid", 32'(instr_valid_o), 32'd0);
        deliver(32'h0050_0093, 32'h0);

        // Sequential, reserved select, branch back, jal forward
        consume(2'b00, 32'h0, 32'h0, 32'h4);
        deliver(32'h0010_0113, 32'h4);
        consume(2'b00, 32'h0, 32'h0, 32'h8);
        deliver(32'h0020_0193, 32'h8);
        consume(2'b11, 32'h55, 32'h77, 32'hC);
        deliver(32'h0030_0213, 32'hC);
        consume(2'b00, 32'h0, 32'h0, 32'h10);
        deliver(32'hFE00_0CE3, 32'h10);
        consume(2'b01, 32'hFFFF_FFF8, 32'h0, 32'h8);
        deliver(32'h0040_0293, 32'h8);
        consume(2'b00, 32'h0, 32'h0, 32'hC);
        deliver(32'h0050_0313, 32'hC);
        consume(2'b00, 32'h0, 32'h0, 32'h10);
        deliver(32'h1000_006F, 32'h10);
        consume(2'b01, 32'h100, 32'h0, 32'h110);
        deliver(32'h0060_0393, 32'h110);

        // Stall five cycles, with a stray response that must be ignored
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem_valid = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end
            #1;
            chk("stall_req", 32'(imem_req), 32'd0);
            tick();
            imem_valid = 1'b0;
            chk("stall_instr", instr_o, 32'h0060_0393);
            chk("stall_pc", pc_o, 32'h110);
            chk("stall_valid", 32'(instr_valid_o), 32'd1);
        end

        // jalr to top of memory, then PC+4 wraps to zero
        consume(2'b10, 32'h0, 32'hFFFF_FFFD, 32'hFFFF_FFFC);
        deliver(32'h0070_0413, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4_o, 32'h0);
        consume(2'b00, 32'h0, 32'h0, 32'h0);
        deliver(32'h0080_0493, 32'h0);

        // jalr with bit1 set
`ifdef MISALIGN_TRAP_EN
        PCSrc     = 2'b10;
        ALUResult = 32'h0000_0203;
        stall     = 1'b0;
        #1;
        chk("mis_req", 32'(imem_req), 32'd0);
        tick();
        stall = 1'b1;
        chk("mis_err", 32'(err_o), 32'd1);
        chk("mis_flag", 32'(misalign_o), 32'd1);
        chk("mis_state", 32'(dbg_state_o), 32'(ST_ERR));
        chk("mis_valid", 32'(instr_valid_o), 32'd0);
        tick();
        chk("mis_req_hold", 32'(imem_req), 32'd0);
`else
        consume(2'b10, 32'h0, 32'h0000_0203, 32'h0000_0200);
        deliver(32'h0090_0513, 32'h200);
`endif

        // Timeout: memory never responds
        rst = 1'b1;
        tick();
        chk("to_rst_state", 32'(dbg_state_o), 32'(ST_IDLE));
        chk("to_rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("to_req", 32'(imem_req), 32'd1);
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_wait15_state", 32'(dbg_state_o), 32'(ST_WAIT));
        chk("to_wait15_err", 32'(err_o), 32'd0);
        tick();
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_state", 32'(dbg_state_o), 32'(ST_ERR));
        chk("to_valid", 32'(instr_valid_o), 32'd0);
        chk("to_req_low", 32'(imem_req), 32'd0);
        imem_valid = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_valid = 1'b0;
        chk("to_terminal", 32'(dbg_state_o), 32'(ST_ERR));
        chk("to_sticky", 32'(err_o), 32'd1);

        // Reset mid-WAIT, late response during IDLE is ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mw_req", 32'(imem_req), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("mw_wait", 32'(dbg_state_o), 32'(ST_WAIT));
        rst = 1'b1;
        #1;
        chk("mw_req_forced", 32'(imem_req), 32'd0);
        tick();
        chk("mw_idle", 32'(dbg_state_o), 32'(ST_IDLE));
        chk("mw_err", 32'(err_o), 32'd0);
        rst        = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("mw_refetch_req", 32'(imem_req), 32'd1);
        chk("mw_refetch_addr", imem_addr, 32'h0);
        tick();
        imem_valid = 1'b0;
        chk("mw_late_state", 32'(dbg_state_o), 32'(ST_WAIT));
        chk("mw_late_instr", instr_o, 32'h0000_0013);
        deliver(32'h0010_0113, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
